// File: rtl/boom_lsu_st.sv
// Shared LSU types and sizing for the refill line buffer.
// Provides line-buffer geometry constants and packed request structs
// used by boom_line_buffer and lb_beat_tracker.
package boom_lsu_st;

  localparam int nMSHRs                 = 4;
  localparam int cacheDataBeats         = 4;
  localparam int beatBits               = 128;
  localparam int log2CeilcacheDataBeats = $clog2(cacheDataBeats);
  localparam int log2CeilnMSHRs         = $clog2(nMSHRs);

  typedef logic [log2CeilnMSHRs-1:0]         lb_id_t;
  typedef logic [log2CeilcacheDataBeats-1:0] lb_off_t;
  typedef logic [beatBits-1:0]               lb_beat_t;

  typedef struct packed {
    lb_id_t   id;
    lb_off_t  offset;
    lb_beat_t data;
  } LineBufferWriteReqST;

  typedef struct packed {
    lb_id_t  id;
    lb_off_t offset;
  } LineBufferReadReqST;

endpackage

// File: rtl/lb_beat_tracker.sv
// Per-entry, per-beat valid bitmap for the refill line buffer.
// Ports: set (write accept) and clear (entry invalidate) requests in;
// bitmap and per-entry line-full flags out. Clear applies before set.
module lb_beat_tracker
  import boom_lsu_st::*;
(
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       set_vld_i,
  input  lb_id_t                                     set_id_i,
  input  lb_off_t                                    set_offset_i,
  input  logic                                       clr_vld_i,
  input  lb_id_t                                     clr_id_i,
  output logic [nMSHRs-1:0][cacheDataBeats-1:0]      beat_valid_o,
  output logic [nMSHRs-1:0]                          line_full_o
);

  logic [nMSHRs-1:0][cacheDataBeats-1:0] bits_q, bits_d;

  // Clear first so a same-cycle write to the cleared entry survives.
  always_comb begin
    bits_d = bits_q;
    if (clr_vld_i) begin
      bits_d[clr_id_i] = '0;
    end
    if (set_vld_i) begin
      bits_d[set_id_i][set_offset_i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  always_comb begin
    line_full_o = '0;
    for (int e = 0; e < nMSHRs; e++) begin
      line_full_o[e] = &bits_q[e];
    end
  end

  assign beat_valid_o = bits_q;

endmodule

// File: rtl/boom_line_buffer.sv
// Refill line buffer: one cache line of storage per MSHR, written beat by
// beat from the refill path and read back with a fixed 1-cycle latency.
// Ports: write req (never back-pressured), read req (stalled by a write),
// read response (no back-pressure), entry clear, beat bitmap, line-full.
module boom_line_buffer
  import boom_lsu_st::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                i_lb_write_valid,
  output logic                                o_lb_write_ready,
  input  logic [log2CeilnMSHRs-1:0]           i_lb_write_id,
  input  logic [log2CeilcacheDataBeats-1:0]   i_lb_write_offset,
  input  logic [beatBits-1:0]                 i_lb_write_data,
  input  logic                                i_lb_read_valid,
  output logic                                o_lb_read_ready,
  input  logic [log2CeilnMSHRs-1:0]           i_lb_read_id,
  input  logic [log2CeilcacheDataBeats-1:0]   i_lb_read_offset,
  output logic                                o_lb_resp_valid,
  output logic [beatBits-1:0]                 o_lb_resp,
  output logic                                o_lb_resp_hit,
  input  logic                                i_clear_valid,
  input  logic [log2CeilnMSHRs-1:0]           i_clear_id,
  output logic [nMSHRs*cacheDataBeats-1:0]    o_beat_valid,
  output logic [nMSHRs-1:0]                   o_line_full
);

  LineBufferWriteReqST wr_req;
  LineBufferReadReqST  rd_req;
  logic                wr_id_ok;
  logic                rd_id_ok;
  logic                wr_acc;
  logic                rd_acc;

  logic [nMSHRs-1:0][cacheDataBeats-1:0] beat_valid;

  logic                resp_valid_q;
  logic [beatBits-1:0] resp_q, resp_d;
  logic                resp_hit_q, resp_hit_d;

  // Not reset: only beats with their valid bit set are meaningful.
  logic [beatBits-1:0] mem_q [nMSHRs][cacheDataBeats];

  assign wr_req = '{id: i_lb_write_id, offset: i_lb_write_offset, data: i_lb_write_data};
  assign rd_req = '{id: i_lb_read_id, offset: i_lb_read_offset};

  // Ids beyond nMSHRs can only exist when nMSHRs is not a power of two.
  if ((1 << log2CeilnMSHRs) == nMSHRs) begin : g_ids_dense
    assign wr_id_ok = 1'b1;
    assign rd_id_ok = 1'b1;
  end else begin : g_ids_sparse
    assign wr_id_ok = (wr_req.id < lb_id_t'(nMSHRs));
    assign rd_id_ok = (rd_req.id < lb_id_t'(nMSHRs));
  end

  // The single array port belongs to the write whenever one is presented.
  assign o_lb_write_ready = !reset;
  assign o_lb_read_ready  = !i_lb_write_valid;

  assign wr_acc = i_lb_write_valid && o_lb_write_ready && wr_id_ok;
  assign rd_acc = i_lb_read_valid && o_lb_read_ready;

  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr_req.id][wr_req.offset] <= wr_req.data;
    end
  end

  lb_beat_tracker u_tracker (
    .clock        (clock),
    .reset        (reset),
    .set_vld_i    (wr_acc),
    .set_id_i     (wr_req.id),
    .set_offset_i (wr_req.offset),
    .clr_vld_i    (i_clear_valid),
    .clr_id_i     (i_clear_id),
    .beat_valid_o (beat_valid),
    .line_full_o  (o_line_full)
  );

  // Data and hit hold their last value; only the valid strobe pulses.
  always_comb begin
    resp_d     = resp_q;
    resp_hit_d = resp_hit_q;
    if (rd_acc) begin
      resp_d     = rd_id_ok ? mem_q[rd_req.id][rd_req.offset] : '0;
      resp_hit_d = rd_id_ok && beat_valid[rd_req.id][rd_req.offset];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      resp_hit_q   <= 1'b0;
    end else begin
      resp_valid_q <= rd_acc;
      resp_q       <= resp_d;
      resp_hit_q   <= resp_hit_d;
    end
  end

  assign o_lb_resp_valid = resp_valid_q;
  assign o_lb_resp       = resp_q;
  assign o_lb_resp_hit   = resp_hit_q;
  assign o_beat_valid    = beat_valid;

  a_wr_id_legal : assert property (@(posedge clock) disable iff (reset)
    i_lb_write_valid |-> wr_id_ok);
  a_rd_id_legal : assert property (@(posedge clock) disable iff (reset)
    i_lb_read_valid |-> rd_id_ok);

endmodule

// File: tb/tb_boom_line_buffer.sv
// Testbench for boom_line_buffer: directed literal checks followed by a
// randomized phase, all compared each cycle against a behavioural model.
module tb_boom_line_buffer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         i_lb_write_valid = 1'b0;
  logic         o_lb_write_ready;
  logic [1:0]   i_lb_write_id = '0;
  logic [1:0]   i_lb_write_offset = '0;
  logic [127:0] i_lb_write_data = '0;
  logic         i_lb_read_valid = 1'b0;
  logic         o_lb_read_ready;
  logic [1:0]   i_lb_read_id = '0;
  logic [1:0]   i_lb_read_offset = '0;
  logic         o_lb_resp_valid;
  logic [127:0] o_lb_resp;
  logic         o_lb_resp_hit;
  logic         i_clear_valid = 1'b0;
  logic [1:0]   i_clear_id = '0;
  logic [15:0]  o_beat_valid;
  logic [3:0]   o_line_full;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  boom_line_buffer dut (
    .clock             (clock),
    .reset             (reset),
    .i_lb_write_valid  (i_lb_write_valid),
    .o_lb_write_ready  (o_lb_write_ready),
    .i_lb_write_id     (i_lb_write_id),
    .i_lb_write_offset (i_lb_write_offset),
    .i_lb_write_data   (i_lb_write_data),
    .i_lb_read_valid   (i_lb_read_valid),
    .o_lb_read_ready   (o_lb_read_ready),
    .i_lb_read_id      (i_lb_read_id),
    .i_lb_read_offset  (i_lb_read_offset),
    .o_lb_resp_valid   (o_lb_resp_valid),
    .o_lb_resp         (o_lb_resp),
    .o_lb_resp_hit     (o_lb_resp_hit),
    .i_clear_valid     (i_clear_valid),
    .i_clear_id        (i_clear_id),
    .o_beat_valid      (o_beat_valid),
    .o_line_full       (o_line_full)
  );

  // Behavioural model: line storage, valid flags, and the last response.
  logic [127:0] m_mem   [4][4];
  bit           m_vb    [4][4];
  bit           m_known [4][4];
  bit           exp_rv;
  bit           exp_hit;
  logic [127:0] exp_rdata;
  bit           exp_known;

  initial begin
    for (int e = 0; e < 4; e++)
      for (int b = 0; b < 4; b++)
        m_known[e][b] = 0;
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < 4; e++)
        for (int b = 0; b < 4; b++)
          m_vb[e][b] = 0;
      exp_rv    = 0;
      exp_hit   = 0;
      exp_rdata = '0;
      exp_known = 1;
    end else begin
      // A read is only taken when no write competes for the array.
      exp_rv = i_lb_read_valid && !i_lb_write_valid;
      if (exp_rv) begin
        exp_rdata = m_mem[i_lb_read_id][i_lb_read_offset];
        exp_hit   = m_vb[i_lb_read_id][i_lb_read_offset];
        exp_known = m_known[i_lb_read_id][i_lb_read_offset];
      end
      if (i_clear_valid)
        for (int b = 0; b < 4; b++)
          m_vb[i_clear_id][b] = 0;
      if (i_lb_write_valid) begin
        m_mem[i_lb_write_id][i_lb_write_offset]   = i_lb_write_data;
        m_vb[i_lb_write_id][i_lb_write_offset]    = 1;
        m_known[i_lb_write_id][i_lb_write_offset] = 1;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [15:0] ebv;
    logic [3:0]  elf;
    if (chk_en) begin
      for (int e = 0; e < 4; e++) begin
        elf[e] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          ebv[e*4+b] = m_vb[e][b];
          if (!m_vb[e][b]) elf[e] = 1'b0;
        end
      end
      check("model_wr_rdy", 128'(o_lb_write_ready), 128'(!reset));
      check("model_rd_rdy", 128'(o_lb_read_ready), 128'(!i_lb_write_valid));
      check("model_beat_valid", 128'(o_beat_valid), 128'(ebv));
      check("model_line_full", 128'(o_line_full), 128'(elf));
      check("model_resp_valid", 128'(o_lb_resp_valid), 128'(exp_rv));
      check("model_resp_hit", 128'(o_lb_resp_hit), 128'(exp_hit));
      if (exp_known) check("model_resp_data", o_lb_resp, exp_rdata);
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] bv;
    repeat (3) begin
      step();
      chk_en = 1;
    end
    reset = 1'b0;
    step();

    // Reset state.
    check("rst_beat_valid", 128'(o_beat_valid), 128'h0);
    check("rst_line_full", 128'(o_line_full), 128'h0);
    check("rst_resp_valid", 128'(o_lb_resp_valid), 128'h0);
    check("rst_resp", o_lb_resp, 128'h0);
    check("rst_resp_hit", 128'(o_lb_resp_hit), 128'h0);

    // Fill entry 2 with A0..A3.
    for (int b = 0; b < 4; b++) begin
      i_lb_write_valid  = 1'b1;
      i_lb_write_id     = 2'd2;
      i_lb_write_offset = 2'(b);
      i_lb_write_data   = 128'hA0 + 128'(b);
      step();
    end
    i_lb_write_valid = 1'b0;
    bv = o_beat_valid;
    check("fill_bits_11_8", 128'(bv[11:8]), 128'hF);
    check("fill_line_full2", 128'(o_line_full[2]), 128'h1);

    // Read entry 2 offset 1.
    i_lb_read_valid  = 1'b1;
    i_lb_read_id     = 2'd2;
    i_lb_read_offset = 2'd1;
    step();
    i_lb_read_valid = 1'b0;
    check("rd_resp_valid", 128'(o_lb_resp_valid), 128'h1);
    check("rd_resp_data", o_lb_resp, 128'hA1);
    check("rd_resp_hit", 128'(o_lb_resp_hit), 128'h1);
    step();
    check("rd_valid_drop", 128'(o_lb_resp_valid), 128'h0);

    // Write and read collide: read stalls, then returns the new data.
    i_lb_write_valid  = 1'b1;
    i_lb_write_id     = 2'd3;
    i_lb_write_offset = 2'd0;
    i_lb_write_data   = 128'hB0;
    i_lb_read_valid   = 1'b1;
    i_lb_read_id      = 2'd3;
    i_lb_read_offset  = 2'd0;
    #1;
    check("coll_rd_rdy_low", 128'(o_lb_read_ready), 128'h0);
    step();
    check("coll_no_resp", 128'(o_lb_resp_valid), 128'h0);
    i_lb_write_valid = 1'b0;
    #1;
    check("coll_rd_rdy_high", 128'(o_lb_read_ready), 128'h1);
    step();
    i_lb_read_valid = 1'b0;
    check("coll_resp_valid", 128'(o_lb_resp_valid), 128'h1);
    check("coll_resp_data", o_lb_resp, 128'hB0);
    check("coll_resp_hit", 128'(o_lb_resp_hit), 128'h1);

    // Clear entry 2 together with a write to its beat 3.
    i_clear_valid     = 1'b1;
    i_clear_id        = 2'd2;
    i_lb_write_valid  = 1'b1;
    i_lb_write_id     = 2'd2;
    i_lb_write_offset = 2'd3;
    i_lb_write_data   = 128'hC3;
    step();
    i_clear_valid    = 1'b0;
    i_lb_write_valid = 1'b0;
    bv = o_beat_valid;
    check("clrwr_bits_11_8", 128'(bv[11:8]), 128'h8);
    check("clrwr_line_full2", 128'(o_line_full[2]), 128'h0);
    i_lb_read_valid  = 1'b1;
    i_lb_read_id     = 2'd2;
    i_lb_read_offset = 2'd0;
    step();
    i_lb_read_valid = 1'b0;
    check("clrwr_rd_hit", 128'(o_lb_resp_hit), 128'h0);

    // Clear entry 1 together with a read of its beat 0.
    i_lb_write_valid  = 1'b1;
    i_lb_write_id     = 2'd1;
    i_lb_write_offset = 2'd0;
    i_lb_write_data   = 128'hD0;
    step();
    i_lb_write_valid = 1'b0;
    i_clear_valid    = 1'b1;
    i_clear_id       = 2'd1;
    i_lb_read_valid  = 1'b1;
    i_lb_read_id     = 2'd1;
    i_lb_read_offset = 2'd0;
    step();
    i_clear_valid = 1'b0;
    check("clrrd_hit_old", 128'(o_lb_resp_hit), 128'h1);
    check("clrrd_data", o_lb_resp, 128'hD0);
    step();
    i_lb_read_valid = 1'b0;
    check("clrrd_hit_new", 128'(o_lb_resp_hit), 128'h0);

    // Reset right after a read accept cancels the response.
    i_lb_read_valid  = 1'b1;
    i_lb_read_id     = 2'd2;
    i_lb_read_offset = 2'd3;
    step();
    i_lb_read_valid = 1'b0;
    check("rstmid_resp_valid_pre", 128'(o_lb_resp_valid), 128'h1);
    reset = 1'b1;
    step();
    check("rstmid_resp_valid", 128'(o_lb_resp_valid), 128'h0);
    check("rstmid_beat_valid", 128'(o_beat_valid), 128'h0);
    reset = 1'b0;
    step();

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      reset             = ($urandom_range(0, 99) == 0);
      i_lb_write_valid  = ($urandom_range(0, 2) == 0);
      i_lb_write_id     = 2'($urandom);
      i_lb_write_offset = 2'($urandom);
      i_lb_write_data   = {$urandom, $urandom, $urandom, $urandom};
      i_lb_read_valid   = ($urandom_range(0, 1) == 0);
      i_lb_read_id      = 2'($urandom);
      i_lb_read_offset  = 2'($urandom);
      i_clear_valid     = ($urandom_range(0, 9) == 0);
      i_clear_id        = 2'($urandom);
      step();
    end
    reset            = 1'b0;
    i_lb_write_valid = 1'b0;
    i_lb_read_valid  = 1'b0;
    i_clear_valid    = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
